// File: rtl/snake_dir_input.sv
// Arrow-button conditioner and two-deep turn queue for the snake engine.
// Sync, debounce, press detection, turn filtering and step-driven release.
module snake_dir_input #(
   parameter int         DEBOUNCE_CYCLES = 200_000,
   parameter logic [3:0] ACTIVE_LOW      = 4'b0011
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_raw,
   input  logic       step,
   output logic [1:0] dir_out,
   output logic [1:0] queue_level,
   output logic       accept_pulse,
   output logic       drop_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    r_stable;
   logic [3:0]    r_stable_d;
   logic [CW-1:0] r_cnt [4];
   logic [1:0]    r_q0;
   logic [1:0]    r_q1;

   logic [3:0]    w_pressed;
   logic [3:0]    w_stable_nx;
   logic [CW-1:0] w_cnt_nx [4];
   logic [3:0]    w_evt;
   logic [3:0]    w_win;
   logic [3:0]    w_lose;
   logic [1:0]    w_req;
   logic          w_req_vld;
   logic [1:0]    w_ref;
   logic          w_rej;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [1:0]    w_dir_nx;
   logic [1:0]    w_q0_nx;
   logic [1:0]    w_q1_nx;
   logic [1:0]    w_lvl_nx;

   assign w_pressed = r_sync2 ^ ACTIVE_LOW;
   assign w_evt     = r_stable & ~r_stable_d;

   // Any cycle of agreement restarts the count, so glitches never accumulate.
   always_comb begin
      w_stable_nx = r_stable;
      for (int i = 0; i < 4; i++) begin
         w_cnt_nx[i] = '0;
         if (w_pressed[i] != r_stable[i]) begin
            if (r_cnt[i] == CNT_LAST)
               w_stable_nx[i] = ~r_stable[i];
            else
               w_cnt_nx[i] = r_cnt[i] + CW'(1);
         end
      end
   end

   always_comb begin
      w_req = 2'd0;
      w_win = 4'b0000;
      priority case (1'b1)
         w_evt[0]: begin w_req = 2'd0; w_win = 4'b0001; end
         w_evt[1]: begin w_req = 2'd1; w_win = 4'b0010; end
         w_evt[2]: begin w_req = 2'd2; w_win = 4'b0100; end
         w_evt[3]: begin w_req = 2'd3; w_win = 4'b1000; end
         default: ;
      endcase
      w_req_vld = |w_evt;
      w_lose    = w_evt & ~w_win;
   end

   // Turns are judged against the last queued turn, not the live heading.
   always_comb begin
      if (queue_level == 2'd0)
         w_ref = dir_out;
      else if (queue_level == 2'd2)
         w_ref = r_q1;
      else
         w_ref = r_q0;
      w_rej  = (w_req[1] == w_ref[1]);
      w_pop  = step && (queue_level != 2'd0);
      w_push = w_req_vld && !w_rej &&
               ((queue_level != 2'd2) || step);
      w_drop = (w_req_vld && !w_push) || (|w_lose);
   end

   always_comb begin
      w_dir_nx = dir_out;
      w_q0_nx  = r_q0;
      w_q1_nx  = r_q1;
      w_lvl_nx = queue_level;
      if (w_pop) begin
         w_dir_nx = r_q0;
         w_q0_nx  = r_q1;
         w_q1_nx  = 2'd0;
         w_lvl_nx = queue_level - 2'd1;
      end
      if (w_push) begin
         if (w_lvl_nx == 2'd0)
            w_q0_nx = w_req;
         else
            w_q1_nx = w_req;
         w_lvl_nx = w_lvl_nx + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1      <= ACTIVE_LOW;
         r_sync2      <= ACTIVE_LOW;
         r_stable     <= 4'b0000;
         r_stable_d   <= 4'b0000;
         for (int i = 0; i < 4; i++)
            r_cnt[i] <= '0;
         r_q0         <= 2'd0;
         r_q1         <= 2'd0;
         dir_out      <= 2'd0;
         queue_level  <= 2'd0;
         accept_pulse <= 1'b0;
         drop_pulse   <= 1'b0;
      end else begin
         r_sync1      <= btn_raw;
         r_sync2      <= r_sync1;
         r_stable     <= w_stable_nx;
         r_stable_d   <= r_stable;
         for (int i = 0; i < 4; i++)
            r_cnt[i] <= w_cnt_nx[i];
         r_q0         <= w_q0_nx;
         r_q1         <= w_q1_nx;
         dir_out      <= w_dir_nx;
         queue_level  <= w_lvl_nx;
         accept_pulse <= w_push;
         drop_pulse   <= w_drop;
      end
   end

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with DEBOUNCE_CYCLES = 4.
// Inputs driven and outputs sampled 1 ns after each rising edge.
module tb_snake_dir_input;

   localparam logic [3:0] IDLE = 4'b0011;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn_raw;
   logic       step;
   logic [1:0] dir_out;
   logic [1:0] queue_level;
   logic       accept_pulse;
   logic       drop_pulse;

   int n_vec = 0;
   int n_err = 0;

   snake_dir_input #(
      .DEBOUNCE_CYCLES(4),
      .ACTIVE_LOW(4'b0011)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_raw(btn_raw),
      .step(step),
      .dir_out(dir_out),
      .queue_level(queue_level),
      .accept_pulse(accept_pulse),
      .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      btn_raw = IDLE;
      step    = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic do_step();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   // Press, hold until the pulse edge, capture pulses, then release fully.
   task automatic press(input logic [3:0] mask, input logic with_step,
                        output logic a, output logic d);
      btn_raw = IDLE ^ mask;
      repeat (6) tick();
      step = with_step;
      tick();
      step = 1'b0;
      a = accept_pulse;
      d = drop_pulse;
      btn_raw = IDLE;
      repeat (8) tick();
   endtask

   initial begin
      logic a;
      logic d;
      int   np;

      // 1: reset values and press latency
      reset   = 1'b0;
      btn_raw = IDLE;
      step    = 1'b0;
      #3;
      check("rst_dir", int'(dir_out), 0);
      check("rst_lvl", int'(queue_level), 0);
      check("rst_acc", int'(accept_pulse), 0);
      check("rst_drop", int'(drop_pulse), 0);
      tick();
      tick();
      reset = 1'b1;
      btn_raw = IDLE ^ 4'b1000;
      repeat (6) tick();
      check("lat_e6_acc", int'(accept_pulse), 0);
      tick();
      check("lat_e7_acc", int'(accept_pulse), 1);
      check("lat_e7_lvl", int'(queue_level), 1);
      check("lat_e7_drop", int'(drop_pulse), 0);
      tick();
      check("acc_width", int'(accept_pulse), 0);
      btn_raw = IDLE;
      do_step();
      check("t1_step_dir", int'(dir_out), 3);
      check("t1_step_lvl", int'(queue_level), 0);
      repeat (8) tick();

      // 2: bounce rejection on up (active-low)
      do_reset();
      np = 0;
      repeat (5) begin
         btn_raw = IDLE ^ 4'b0001;
         repeat (3) begin
            tick();
            np += int'(accept_pulse) + int'(drop_pulse);
         end
         btn_raw = IDLE;
         tick();
         np += int'(accept_pulse) + int'(drop_pulse);
      end
      btn_raw = IDLE ^ 4'b0001;
      repeat (6) begin
         tick();
         np += int'(accept_pulse) + int'(drop_pulse);
      end
      btn_raw = IDLE;
      check("bounce_quiet", np, 0);
      tick();
      check("bounce_drop", int'(drop_pulse), 1);
      check("bounce_acc", int'(accept_pulse), 0);
      check("bounce_lvl", int'(queue_level), 0);
      repeat (10) tick();

      // 3: reversal filter
      do_reset();
      press(4'b0010, 1'b0, a, d);
      check("rev_down_drop", int'(d), 1);
      check("rev_down_acc", int'(a), 0);
      check("rev_down_lvl", int'(queue_level), 0);
      press(4'b0100, 1'b0, a, d);
      check("rev_left_acc", int'(a), 1);
      check("rev_left_lvl", int'(queue_level), 1);
      press(4'b1000, 1'b0, a, d);
      check("rev_right_drop", int'(d), 1);
      check("rev_right_acc", int'(a), 0);
      check("rev_right_lvl", int'(queue_level), 1);

      // 4: double turn
      do_reset();
      press(4'b1000, 1'b0, a, d);
      check("dbl_r_acc", int'(a), 1);
      press(4'b0010, 1'b0, a, d);
      check("dbl_d_acc", int'(a), 1);
      check("dbl_lvl2", int'(queue_level), 2);
      do_step();
      check("dbl_s1_dir", int'(dir_out), 3);
      check("dbl_s1_lvl", int'(queue_level), 1);
      do_step();
      check("dbl_s2_dir", int'(dir_out), 1);
      check("dbl_s2_lvl", int'(queue_level), 0);
      do_step();
      check("dbl_s3_dir", int'(dir_out), 1);
      check("dbl_s3_lvl", int'(queue_level), 0);

      // 5: full queue, then push with same-cycle step
      do_reset();
      press(4'b1000, 1'b0, a, d);
      press(4'b0010, 1'b0, a, d);
      press(4'b0100, 1'b0, a, d);
      check("full_drop", int'(d), 1);
      check("full_acc", int'(a), 0);
      check("full_lvl", int'(queue_level), 2);
      check("full_dir", int'(dir_out), 0);
      press(4'b0100, 1'b1, a, d);
      check("pp_acc", int'(a), 1);
      check("pp_drop", int'(d), 0);
      check("pp_dir", int'(dir_out), 3);
      check("pp_lvl", int'(queue_level), 2);
      do_step();
      check("pp_s1_dir", int'(dir_out), 1);
      do_step();
      check("pp_s2_dir", int'(dir_out), 2);
      check("pp_s2_lvl", int'(queue_level), 0);

      // 6: priority, then async reset mid-debounce
      do_reset();
      press(4'b1000, 1'b0, a, d);
      do_step();
      check("pri_pre_dir", int'(dir_out), 3);
      press(4'b0101, 1'b0, a, d);
      check("pri_acc", int'(a), 1);
      check("pri_drop", int'(d), 1);
      check("pri_lvl", int'(queue_level), 1);
      btn_raw = IDLE ^ 4'b0010;
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      check("arst_dir", int'(dir_out), 0);
      check("arst_lvl", int'(queue_level), 0);
      check("arst_acc", int'(accept_pulse), 0);
      check("arst_drop", int'(drop_pulse), 0);
      #2;
      reset = 1'b1;
      repeat (6) tick();
      check("rdeb_e6_drop", int'(drop_pulse), 0);
      tick();
      check("rdeb_e7_drop", int'(drop_pulse), 1);
      check("rdeb_e7_acc", int'(accept_pulse), 0);
      btn_raw = IDLE;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
